// File: rtl/prbs_ber_checker.sv
// PRBS9 bit-error-rate checker that slices equalizer output, locks a free-running
// reference onto the incoming stream, and counts errors, relocking on bursts.
module prbs_ber_checker #(
  parameter int NBin   = 8,
  parameter int NBFin  = 5,
  parameter int WIN    = 64,
  parameter int ERR_TH = 8,
  parameter int NBcnt  = 32
) (
  input  logic             clkA,
  input  logic             reset,
  input  logic [NBin-1:0]  y,
  input  logic             valid_in,
  input  logic             clr,
  output logic             dec_out,
  output logic             dec_valid,
  output logic             locked,
  output logic [NBcnt-1:0] bit_count,
  output logic [NBcnt-1:0] err_count,
  output logic [7:0]       relock_count
);

  localparam int WCW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int WEW = $clog2(WIN + 1);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WIN - 1);
  localparam logic [WEW-1:0] ERR_TH_W = WEW'(ERR_TH);

  // The slicer only looks at the sign bit; the format must leave room for it.
  if (NBFin >= NBin) begin : g_bad_fmt
    $error("prbs_ber_checker: NBFin must be smaller than NBin");
  end

  typedef enum logic {LOAD = 1'b0, CHECK = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [8:0]       r_s;
  logic [3:0]       r_ld_cnt;
  logic [WCW-1:0]   r_win_cnt;
  logic [WEW-1:0]   r_win_err;
  logic             r_dec_out;
  logic             r_dec_valid;
  logic [NBcnt-1:0] r_bit_count;
  logic [NBcnt-1:0] r_err_count;
  logic [7:0]       r_relock_count;

  logic             w_d;
  logic             w_e;
  logic             w_err;
  logic [8:0]       w_s_load;
  logic             w_ld_last;
  logic             w_win_end;
  logic [WEW-1:0]   w_win_err_sum;
  logic             w_relock;

  assign w_d           = y[NBin-1];
  assign w_e           = r_s[8] ^ r_s[4];
  assign w_err         = w_d ^ w_e;
  assign w_s_load      = {r_s[7:0], w_d};
  assign w_ld_last     = (r_ld_cnt == 4'd8);
  assign w_win_end     = (r_win_cnt == WIN_LAST);
  assign w_win_err_sum = r_win_err + WEW'(w_err);
  assign w_relock      = valid_in && (r_state == CHECK) && w_win_end &&
                         (w_win_err_sum >= ERR_TH_W);

  always_ff @(posedge clkA) begin
    if (reset) r_state <= LOAD;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (valid_in) begin
      case (r_state)
        LOAD:    if (w_ld_last && (w_s_load != 9'd0)) w_state_nxt = CHECK;
        CHECK:   if (w_relock) w_state_nxt = LOAD;
        default: w_state_nxt = LOAD;
      endcase
    end
  end

  always_ff @(posedge clkA) begin
    if (reset) begin
      r_s            <= '0;
      r_ld_cnt       <= '0;
      r_win_cnt      <= '0;
      r_win_err      <= '0;
      r_dec_out      <= 1'b0;
      r_dec_valid    <= 1'b0;
      r_bit_count    <= '0;
      r_err_count    <= '0;
      r_relock_count <= '0;
    end else begin
      r_dec_valid <= valid_in;
      if (valid_in) begin
        r_dec_out <= w_d;
        if (r_state == LOAD) begin
          r_s       <= w_s_load;
          r_ld_cnt  <= w_ld_last ? 4'd0 : r_ld_cnt + 4'd1;
          r_win_cnt <= '0;
          r_win_err <= '0;
        end else begin
          // Reference free-runs on its own prediction, never on the received bit.
          r_s      <= {r_s[7:0], w_e};
          r_ld_cnt <= '0;
          if (r_bit_count != '1) r_bit_count <= r_bit_count + 1'b1;
          if (w_err && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
          if (w_win_end) begin
            r_win_cnt <= '0;
            r_win_err <= '0;
            if (w_relock && (r_relock_count != 8'hFF))
              r_relock_count <= r_relock_count + 8'd1;
          end else begin
            r_win_cnt <= r_win_cnt + 1'b1;
            r_win_err <= w_win_err_sum;
          end
        end
      end
      if (clr) begin
        r_bit_count    <= '0;
        r_err_count    <= '0;
        r_relock_count <= '0;
      end
    end
  end

  assign dec_out      = r_dec_out;
  assign dec_valid    = r_dec_valid;
  assign locked       = (r_state == CHECK);
  assign bit_count    = r_bit_count;
  assign err_count    = r_err_count;
  assign relock_count = r_relock_count;

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Bench for prbs_ber_checker: directed table, PRBS scenarios and a randomized run
// checked every cycle against a queue-based reference model.
module tb_prbs_ber_checker;

  localparam int WIN    = 64;
  localparam int ERR_TH = 8;

  logic        clkA = 1'b0;
  logic        reset, valid_in, clr;
  logic [7:0]  y;
  logic        dec_out, dec_valid, locked;
  logic [31:0] bit_count, err_count;
  logic [7:0]  relock_count;

  prbs_ber_checker #(.NBin(8), .NBFin(5), .WIN(WIN), .ERR_TH(ERR_TH), .NBcnt(32)) dut (
    .clkA(clkA), .reset(reset), .y(y), .valid_in(valid_in), .clr(clr),
    .dec_out(dec_out), .dec_valid(dec_valid), .locked(locked),
    .bit_count(bit_count), .err_count(err_count), .relock_count(relock_count)
  );

  always #5 clkA = ~clkA;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: last 9 reference bits, oldest first
  bit     m_hist[$];
  bit     m_locked, m_dec, m_decv;
  int     m_ld, m_wcnt, m_werr, m_relock;
  longint m_bit, m_err;

  // PRBS9 source: last 9 emitted bits, oldest first
  bit g_q[$];
  bit g_save[$];

  typedef struct {
    bit         rst;
    bit         v;
    bit         c;
    logic [7:0] yy;
    bit         e_locked;
    bit         e_dv;
    bit         e_dec;
    int         e_bit;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i < 9; i++) m_hist.push_back(1'b0);
    m_locked = 0; m_dec = 0; m_decv = 0;
    m_ld = 0; m_wcnt = 0; m_werr = 0; m_relock = 0;
    m_bit = 0; m_err = 0;
  endtask

  task automatic model_step(input bit r, input bit v, input logic [7:0] yy, input bit c);
    bit d, e, er, nz;
    if (r) begin
      model_reset();
      return;
    end
    m_decv = v;
    if (v) begin
      d = yy[7];
      m_dec = d;
      if (!m_locked) begin
        m_hist.push_back(d);
        void'(m_hist.pop_front());
        m_ld++;
        if (m_ld == 9) begin
          m_ld = 0;
          nz = 0;
          foreach (m_hist[i]) nz |= m_hist[i];
          m_locked = nz;
        end
      end else begin
        e  = m_hist[0] ^ m_hist[4];
        er = (d != e);
        m_hist.push_back(e);
        void'(m_hist.pop_front());
        if (m_bit < 64'hFFFF_FFFF) m_bit++;
        if (er && m_err < 64'hFFFF_FFFF) m_err++;
        m_werr += int'(er);
        m_wcnt++;
        if (m_wcnt == WIN) begin
          if (m_werr >= ERR_TH) begin
            m_locked = 0;
            m_ld = 0;
            if (m_relock < 255) m_relock++;
          end
          m_wcnt = 0;
          m_werr = 0;
        end
      end
    end
    if (c) begin
      m_bit = 0; m_err = 0; m_relock = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit v, input logic [7:0] yy, input bit c);
    reset = r; valid_in = v; y = yy; clr = c;
    @(posedge clkA);
    #1;
    model_step(r, v, yy, c);
    chk("locked", longint'(locked), longint'(m_locked));
    chk("dec_valid", longint'(dec_valid), longint'(m_decv));
    if (m_decv) chk("dec_out", longint'(dec_out), longint'(m_dec));
    chk("bit_count", longint'(bit_count), m_bit);
    chk("err_count", longint'(err_count), m_err);
    chk("relock_count", longint'(relock_count), longint'(m_relock));
  endtask

  function automatic logic [7:0] yv(input bit b);
    return b ? 8'hE0 : 8'h20;
  endfunction

  function automatic logic [7:0] yrand(input bit b);
    if (b) return 8'(9'd256 - 9'($urandom_range(1, 128)));
    return 8'($urandom_range(0, 127));
  endfunction

  task automatic gen_seed();
    bit nz = 0;
    g_q = {};
    for (int i = 0; i < 9; i++) begin
      g_q.push_back(1'($urandom_range(0, 1)));
      nz |= g_q[i];
    end
    if (!nz) g_q[3] = 1'b1;
  endtask

  task automatic gen_next(output bit b);
    b = g_q[0] ^ g_q[4];
    g_q.push_back(b);
    void'(g_q.pop_front());
  endtask

  task automatic do_reset();
    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
  endtask

  task automatic send(input bit inj, input bit c);
    bit b;
    gen_next(b);
    cyc(0, 1, yv(b ^ inj), c);
  endtask

  task automatic idle();
    cyc(0, 0, 8'($urandom), 0);
  endtask

  task automatic load9();
    for (int i = 0; i < 9; i++) begin
      send(0, 0);
      if (i == 7) chk("not_locked_after_8", longint'(locked), 0);
    end
    chk("locked_after_9", longint'(locked), 1);
  endtask

  task automatic gap_run(input bit gaps);
    g_q = g_save;
    do_reset();
    for (int i = 0; i < 209; i++) begin
      send((i == 26) || (i == 99) || (i == 159), 0);
      if (gaps) repeat ($urandom_range(0, 2)) idle();
    end
    chk(gaps ? "gapped_bits" : "gapless_bits", longint'(bit_count), 200);
    chk(gaps ? "gapped_errs" : "gapless_errs", longint'(err_count), 3);
  endtask

  initial begin
    bit b, inj;
    longint err_at_relock;
    int burst;
    model_reset();
    reset = 1; valid_in = 0; clr = 0; y = 8'h00;

    // reset with valid traffic, then first samples after reset
    tbl[0] = '{1, 1, 0, 8'($urandom), 0, 0, 0, 0};
    tbl[1] = '{1, 1, 1, 8'($urandom), 0, 0, 0, 0};
    tbl[2] = '{0, 1, 0, 8'h85,        0, 1, 1, 0};
    tbl[3] = '{0, 0, 0, 8'h10,        0, 0, 1, 0};
    tbl[4] = '{0, 1, 0, 8'h00,        0, 1, 0, 0};
    tbl[5] = '{0, 1, 1, 8'h7F,        0, 1, 0, 0};
    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].v, tbl[i].yy, tbl[i].c);
      chk("tbl_locked", longint'(locked), longint'(tbl[i].e_locked));
      chk("tbl_dec_valid", longint'(dec_valid), longint'(tbl[i].e_dv));
      chk("tbl_dec_out", longint'(dec_out), longint'(tbl[i].e_dec));
      chk("tbl_bit_count", longint'(bit_count), longint'(tbl[i].e_bit));
      chk("tbl_relock", longint'(relock_count), 0);
    end

    // clean stream
    do_reset(); gen_seed(); load9();
    repeat (1000) send(0, 0);
    chk("clean_bits", longint'(bit_count), 1000);
    chk("clean_errs", longint'(err_count), 0);
    chk("clean_relock", longint'(relock_count), 0);

    // one inverted symbol every 100 compared samples
    do_reset(); gen_seed(); load9();
    for (int k = 0; k < 1000; k++) send((k % 100) == 99, 0);
    chk("inv_errs", longint'(err_count), 10);
    chk("inv_locked", longint'(locked), 1);

    // stream jumps 100 positions mid-window
    do_reset(); gen_seed(); load9();
    repeat (30) send(0, 0);
    repeat (100) gen_next(b);
    for (int k = 0; k < 34; k++) begin
      send(0, 0);
      if (k == 32) chk("jump_still_locked", longint'(locked), 1);
    end
    chk("jump_unlocked_at_window_end", longint'(locked), 0);
    chk("jump_relock_count", longint'(relock_count), 1);
    err_at_relock = m_err;
    load9();
    repeat (100) send(0, 0);
    chk("jump_no_new_errs", longint'(err_count), err_at_relock);
    chk("jump_bits", longint'(bit_count), 164);

    // all-zero input never locks
    do_reset();
    repeat (50) cyc(0, 1, 8'h00, 0);
    chk("zero_locked", longint'(locked), 0);
    chk("zero_bits", longint'(bit_count), 0);

    // clr coinciding with an error, valid toggling
    do_reset(); gen_seed();
    for (int i = 0; i < 9; i++) begin send(0, 0); idle(); end
    chk("toggle_locked", longint'(locked), 1);
    for (int k = 0; k < 20; k++) begin
      send(k == 10, k == 10);
      if (k == 10) begin
        chk("clr_bits", longint'(bit_count), 0);
        chk("clr_errs", longint'(err_count), 0);
        chk("clr_relock", longint'(relock_count), 0);
        chk("clr_keeps_lock", longint'(locked), 1);
      end
      idle();
    end
    chk("after_clr_bits", longint'(bit_count), 9);

    // gapped and gapless runs of the same stream give the same counts
    gen_seed();
    g_save = g_q;
    gap_run(1);
    gap_run(0);

    // randomized traffic with error bursts, clr and occasional reset
    do_reset(); gen_seed();
    burst = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) burst = $urandom_range(20, 80);
      if ($urandom_range(0, 1499) == 0) begin
        cyc(1, 1, 8'($urandom), 0);
      end else if ($urandom_range(0, 3) != 0) begin
        gen_next(b);
        inj = (burst > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
        cyc(0, 1, yrand(b ^ inj), $urandom_range(0, 199) == 0);
        if (burst > 0) burst--;
      end else begin
        cyc(0, 0, 8'($urandom), $urandom_range(0, 199) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_ber_checker.md
PRBS_BER_CHECKER -- requirements
Module: prbs_ber_checker

Interface
REQ-001 Parameters SHALL be as listed, one per line as name, default, meaning.
- NBin, 8, equalizer output width.
- NBFin, 5, fractional bits of y (signed S(NBin,NBFin)).
- WIN, 64, error-monitor window length in compared symbols.
- ERR_TH, 8, window error count that forces relock.
- NBcnt, 32, width of bit_count and err_count.
REQ-002 Ports SHALL be as listed, one per line as name, direction, width, meaning.
- clkA, in, 1, single clock; all logic on rising edge.
- reset, in, 1, synchronous, active-high reset.
- y, in, NBin, signed equalizer output sample.
- valid_in, in, 1, y is valid this cycle.
- clr, in, 1, synchronous clear of bit_count, err_count and relock_count.
- dec_out, out, 1, sliced decision bit.
- dec_valid, out, 1, dec_out valid.
- locked, out, 1, 1 while in CHECK.
- bit_count, out, NBcnt, symbols compared in CHECK, saturating.
- err_count, out, NBcnt, mismatches in CHECK, saturating.
- relock_count, out, 8, CHECK->LOAD transitions, saturating at 255.

Function
REQ-003 The block SHALL sit downstream of the LMS equalizer and consume one y per valid_in=1 cycle; valid_in=0 cycles SHALL change no state and SHALL not advance the PRBS.
REQ-004 The slicer SHALL set decision d = y[NBin-1]: y>=0 gives d=0 (symbol +1) and y<0 gives d=1 (symbol -1); zero SHALL slice to 0.
REQ-005 dec_out SHALL be d registered, and dec_valid SHALL be valid_in registered, both with 1-cycle latency.
REQ-006 The reference SHALL be PRBS9 x^9+x^5+1 held in a 9-bit register s, with expected bit e = s[8]^s[4].
REQ-007 The FSM SHALL have two states, LOAD and CHECK.
REQ-008 In LOAD, each valid sample SHALL shift s <= {s[7:0], d} and increment a load counter ld_cnt (0..8).
REQ-009 On the 9th load sample the FSM SHALL enter CHECK if the resulting s is nonzero; otherwise it SHALL clear ld_cnt and remain in LOAD.
REQ-010 In CHECK, each valid sample SHALL compute err = (d != e) and shift s <= {s[7:0], e}, so the PRBS free-runs and never reloads from d.
REQ-011 locked SHALL equal 1 exactly when state is CHECK; it SHALL read 1 after the edge that captures the 9th load sample.
REQ-012 The first comparison SHALL occur on the next valid sample after that edge.
REQ-013 In CHECK, each valid sample SHALL increment bit_count by 1 and SHALL add err to err_count, both saturating at 2^NBcnt-1.
REQ-014 Window counters SHALL run only in CHECK: win_cnt counts 0..WIN-1 and win_err accumulates err.
REQ-015 On the sample where win_cnt==WIN-1, if win_err+err >= ERR_TH the FSM SHALL go to LOAD, clear ld_cnt and increment relock_count; otherwise it SHALL clear win_cnt and win_err and stay in CHECK.
REQ-016 In both cases of REQ-015, the current sample SHALL still update bit_count and err_count.
REQ-017 Entering LOAD SHALL clear win_cnt and win_err.
REQ-018 When clr=1, bit_count, err_count and relock_count SHALL be 0 after that edge, and the same cycle's increments SHALL be discarded (clr wins).
REQ-019 clr SHALL not affect the FSM, s, the window counters or dec_out.
REQ-020 A relock and clr in the same cycle SHALL leave relock_count=0 and state=LOAD.

Reset
REQ-021 When reset=1 at an edge, the block SHALL set state=LOAD, s=0, ld_cnt=0, win_cnt=0, win_err=0, and all outputs to 0, regardless of valid_in or clr.
REQ-022 A reset asserted mid-CHECK SHALL discard lock; after reset falls, 9 new valid samples SHALL be required to relock.

Verification
REQ-023 The bench SHALL cover the directed scenarios listed, one per line as stimulus -> required response.
- reset=1 for 2 cycles with valid_in=1 and random y -> all outputs 0; locked=0 on the first valid sample after reset falls.
- Clean PRBS9 at random phase, bit0=8'h20 (+1.0), bit1=8'hE0 (-1.0), valid_in=1 every cycle -> locked=1 after the 9th sample; after 1000 further samples bit_count=1000, err_count=0, relock_count=0.
- Same stream with y sign inverted on every 100th compared sample -> after 1000 samples err_count=10 and locked stays 1.
- Stream jumped forward 100 PRBS positions while locked (about 50% errors) -> locked falls at the end of the current window and relock_count=1; it relocks 9 samples later with no further errors.
- y=8'h00 constantly -> locked never asserts and bit_count stays 0 (all-zero load rejected).
- clr=1 in the same cycle as an error, with valid_in toggling 1010... -> counters 0 after that edge; stream with valid_in=0 gaps gives identical counts to a gapless run.
